// File: rtl/seq_div_32by16.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_32by16
//  Description : Iterative unsigned restoring divider. Divides a 2*WIDTH-bit
//                dividend by a WIDTH-bit divisor, one quotient bit per clock,
//                with valid/ready handshakes on input and output. Divide by
//                zero and quotient overflow are flagged and answered at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div_32by16 #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_zero,
   output logic               ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   // Partial remainder: after every iteration R < divisor, so W bits hold it.
   logic [WIDTH-1:0]   rem_q,   rem_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   quot_q,  quot_d;
   logic [WIDTH-1:0]   dvs_q,   dvs_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               dz_q,    dz_d;
   logic               ovf_q,   ovf_d;

   // Trial values for the current iteration, W+1 bits wide so nothing is lost.
   logic [WIDTH:0]     r_shift;
   logic [WIDTH:0]     r_sub;
   logic [WIDTH-1:0]   div_hi;
   logic [WIDTH-1:0]   div_lo;

   assign div_hi  = dividend[2*WIDTH-1:WIDTH];
   assign div_lo  = dividend[WIDTH-1:0];
   assign r_shift = {rem_q, shift_q[WIDTH-1]};
   assign r_sub   = r_shift - {1'b0, dvs_q};

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
   assign ovf       = ovf_q;

   // Register bank; asynchronous reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         shift_q <= '0;
         quot_q  <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         shift_q <= shift_d;
         quot_q  <= quot_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath: accept/classify in IDLE, one restoring step per CALC cycle.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      quot_d  = quot_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvs_d = divisor;
               if (divisor == '0) begin
                  dz_d    = 1'b1;
                  ovf_d   = 1'b0;
                  quot_d  = '1;
                  rem_d   = div_lo;
                  state_d = S_DONE;
               end else if (div_hi >= divisor) begin
                  // Quotient would need more than WIDTH bits.
                  dz_d    = 1'b0;
                  ovf_d   = 1'b1;
                  quot_d  = '1;
                  rem_d   = div_lo;
                  state_d = S_DONE;
               end else begin
                  dz_d    = 1'b0;
                  ovf_d   = 1'b0;
                  rem_d   = div_hi;
                  shift_d = div_lo;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (r_shift >= {1'b0, dvs_q}) begin
               rem_d  = r_sub[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = r_shift[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_div_32by16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_div_32by16
//  Description : Self-checking bench for seq_div_32by16 with an expected-result
//                queue filled on accept and drained on out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div_32by16;

   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2*W-1:0]   dividend;
   logic [W-1:0]     divisor;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     quotient;
   logic [W-1:0]     remainder;
   logic             div_zero;
   logic             ovf;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_div_32by16 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model from plain integer division.
   function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
      exp_t e;
      longint unsigned a, b;
      a = 64'(dd);
      b = 64'(dv);
      if (dv == '0) begin
         e = '{q: '1, r: dd[W-1:0], dz: 1'b1, ov: 1'b0};
      end else if ((a >> W) >= b) begin
         e = '{q: '1, r: dd[W-1:0], dz: 1'b0, ov: 1'b1};
      end else begin
         e = '{q: W'(a / b), r: W'(a % b), dz: 1'b0, ov: 1'b0};
      end
      return e;
   endfunction

   // Drive one operation; returns at accept edge + 1.
   task automatic send(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      exp_q.push_back(model(dd, dv));
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = W'($urandom);
   endtask

   // Wait for out_valid, report latency in edges from the accept edge.
   task automatic wait_out(output int lat);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
      lat = k + 1;
   endtask

   // Pop the expected result and compare every output field.
   task automatic compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check(tag, {quotient, remainder, div_zero, ovf}, {e.q, e.r, e.dz, e.ov});
      end
   endtask

   // Full operation with out_ready held high; checks handshake drop afterwards.
   task automatic run_op(input string tag, input logic [2*W-1:0] dd,
                         input logic [W-1:0] dv, input int exp_lat);
      int lat;
      send(dd, dv);
      wait_out(lat);
      compare(tag);
      if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      @(posedge clk); #1;
      if (exp_lat > 0) check({tag, "_consumed"}, {63'd0, out_valid}, 0);
   endtask

   initial begin
      logic [W-1:0]   q_hold, r_hold;
      logic [W-1:0]   a, b;
      logic [2*W-1:0] dd;
      int             lat;

      rst       = 1'b1;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {out_valid, in_ready, quotient, remainder, div_zero, ovf},
            {1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0});
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      run_op("basic", 32'h0000_0C39, 16'h0031, 17);
      check("basic_hold_q", 64'(quotient), 64'h003F);
      run_op("full_range", 32'hFFFE_0001, 16'hFFFF, 17);
      run_op("div_zero", 32'h1234_5678, 16'h0000, 1);
      run_op("overflow", 32'h0010_0000, 16'h0010, 1);
      run_op("small", 32'h0000_0000, 16'h0001, 17);

      // Backpressure: result must hold and new requests must be ignored
      out_ready = 1'b0;
      send(32'h0000_0C39, 16'h0031);
      wait_out(lat);
      q_hold = quotient;
      r_hold = remainder;
      compare("bp_result");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         dividend = 32'h0000_0001;
         divisor  = 16'h0001;
         @(posedge clk); #1;
         check("bp_hold", {out_valid, in_ready, quotient, remainder},
               {1'b1, 1'b0, q_hold, r_hold});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
      run_op("back_to_back", 32'h0000_0064, 16'h0007, 17);

      // Reset in the middle of a computation
      send(32'h1234_0000, 16'h8000);
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_state", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("after_reset", 32'h0009_C400, 16'h0100, 17);

      // Random operands, including product words that must divide back exactly
      for (int i = 0; i < 1500; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 5))
            0: begin
               if (b == '0) b = 16'h0001;
               dd = a * b;
               run_op("rand_product", dd, b, 0);
               check("rand_product_inverse", 64'(quotient), 64'(a));
            end
            1: run_op("rand_zero", $urandom, 16'h0000, 0);
            2: run_op("rand_any", $urandom, b, 0);
            default: begin
               if (b == '0) b = 16'h0001;
               dd = {W'($urandom_range(0, int'(b) - 1)), W'($urandom)};
               run_op("rand_normal", dd, b, 0);
               check("rand_invariant",
                     {31'd0, (32'(quotient) * 32'(b) + 32'(remainder) == dd) && (remainder < b)},
                     1);
            end
         endcase
      end

      check("queue_drained", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
